// File: rtl/lgbs_link_pkg.sv
// Shared constants for the UART command/acknowledge link: command bytes,
// response status codes and the one-hot sequencer state encoding.
package lgbs_link_pkg;

  localparam logic [7:0] CMD_TURN_ON  = 8'hAA;
  localparam logic [7:0] CMD_TURN_OFF = 8'h55;
  localparam logic [7:0] CMD_TOGGLE   = 8'hC3;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_TIMEOUT  = 2'b01;
  localparam logic [1:0] ST_MISMATCH = 2'b10;
  localparam logic [1:0] ST_PARITY   = 2'b11;

  typedef enum logic [5:0] {
    S_IDLE      = 6'b000001,
    S_LOAD      = 6'b000010,
    S_TX_WAIT   = 6'b000100,
    S_ECHO_WAIT = 6'b001000,
    S_GUARD     = 6'b010000,
    S_REPORT    = 6'b100000
  } state_t;

  // The timer spends (value + 1) cycles in a phase, the last one being the
  // expiry cycle, so a phase of n cycles loads n-1.
  function automatic int load_count(input int cycles);
    return (cycles > 0) ? cycles - 1 : 0;
  endfunction

endpackage

// File: rtl/link_timer.sv
// Loadable down-counter shared by the TX, echo and guard phases; saturates at
// zero and reports expiry while the count is zero.
module link_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              count <= '0;
    else if (load)           count <= value;
    else if (count != '0)    count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_link_sequencer.sv
// Sends one command byte through uart_tx, waits for the far side to echo it on
// uart_rx, retries after a guard gap on failure and reports one status per command.
module uart_link_sequencer
  import lgbs_link_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 480000,
  parameter  int GUARD_CYCLES   = 4800,
  parameter  int MAX_RETRIES    = 3,
  localparam int AW             = $clog2(MAX_RETRIES + 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [7:0]    cmd_data,
  output logic          cmd_ready,
  output logic [7:0]    data_to_tx,
  output logic          start_tx,
  input  logic          tx_busy,
  input  logic [7:0]    data_received,
  input  logic          rx_done,
  input  logic          parity_error,
  output logic          rsp_valid,
  output logic [1:0]    rsp_status,
  output logic [AW-1:0] rsp_attempts,
  output logic [7:0]    rsp_data,
  output logic          busy
);

  localparam int TMAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(load_count(TIMEOUT_CYCLES));
  localparam logic [TW-1:0] GD_LOAD = TW'(load_count(GUARD_CYCLES));
  localparam logic [AW-1:0] MAX_ATT = AW'(MAX_RETRIES + 1);

  state_t        state;
  logic          seen_busy;
  logic          tx_fall;
  logic          retry;
  logic          fail_now;
  logic [1:0]    fail_cause;
  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          expired;

  assign tx_fall = seen_busy & ~tx_busy;
  assign retry   = (rsp_attempts < MAX_ATT);

  // An echo arriving in the expiry cycle still counts as received.
  always_comb begin
    fail_now   = 1'b0;
    fail_cause = ST_TIMEOUT;
    case (state)
      S_TX_WAIT:   if (!tx_fall && expired) fail_now = 1'b1;
      S_ECHO_WAIT: begin
        if (rx_done) begin
          if (parity_error) begin
            fail_now   = 1'b1;
            fail_cause = ST_PARITY;
          end else if (data_received != data_to_tx) begin
            fail_now   = 1'b1;
            fail_cause = ST_MISMATCH;
          end
        end else if (expired) begin
          fail_now = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    timer_load  = (state == S_LOAD) || ((state == S_TX_WAIT) && tx_fall) || (fail_now && retry);
    timer_value = fail_now ? GD_LOAD : TO_LOAD;
  end

  link_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .value   (timer_value),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      start_tx     <= 1'b0;
      rsp_valid    <= 1'b0;
      data_to_tx   <= '0;
      rsp_status   <= ST_OK;
      rsp_attempts <= '0;
      rsp_data     <= '0;
      seen_busy    <= 1'b0;
    end else begin
      start_tx  <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          data_to_tx   <= cmd_data;
          rsp_attempts <= '0;
          rsp_status   <= ST_OK;
          rsp_data     <= '0;
          start_tx     <= 1'b1;
          cmd_ready    <= 1'b0;
          busy         <= 1'b1;
          state        <= S_LOAD;
        end
        S_LOAD: begin
          if (rsp_attempts != MAX_ATT) rsp_attempts <= rsp_attempts + 1'b1;
          seen_busy <= 1'b0;
          state     <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          seen_busy <= seen_busy | tx_busy;
          if (tx_fall) state <= S_ECHO_WAIT;
        end
        S_ECHO_WAIT: if (rx_done) begin
          rsp_data <= data_received;
          if (!fail_now) begin
            rsp_status <= ST_OK;
            rsp_valid  <= 1'b1;
            state      <= S_REPORT;
          end
        end
        S_GUARD: if (expired) begin
          start_tx <= 1'b1;
          state    <= S_LOAD;
        end
        S_REPORT: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
      // Failure handling overrides the per-state next state above.
      if (fail_now) begin
        rsp_status <= fail_cause;
        if (retry) begin
          state <= S_GUARD;
        end else begin
          rsp_valid <= 1'b1;
          state     <= S_REPORT;
        end
      end
    end
  end

endmodule
